hyperbus_delay_tap_ctrl: RTL and testbench

//  Sequences tap changes of the HyperBus RWDS programmable delay line (PROGDEL8-style, one-hot select).

---
 rtl/hyperbus_delay_pkg.sv | 22 ++
 rtl/hyperbus_delay_tap_ctrl.sv | 106 ++++++++++
 tb/tb_hyperbus_delay_tap_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/hyperbus_delay_pkg.sv
// hyperbus_delay_pkg: shared types and helpers for the HyperBus RWDS delay-tap controller.
//   state_t     controller FSM states
//   tap_idx_t   generic tap index, wide enough for any supported NUM_TAPS
//   onehot_tap  tap index -> one-hot select (truncate to NUM_TAPS at the call site)
//   clamp_tap   limit a requested index to the last implemented tap
package hyperbus_delay_pkg;

    localparam int MAX_TAPS = 256;

    typedef enum logic [1:0] {IDLE, WAIT_IDLE, APPLY, SETTLE} state_t;

    typedef logic [7:0] tap_idx_t;

    function automatic logic [MAX_TAPS-1:0] onehot_tap(input tap_idx_t idx);
        return MAX_TAPS'(1) << idx;
    endfunction

    function automatic tap_idx_t clamp_tap(input tap_idx_t idx, input int num_taps);
        return int'(idx) >= num_taps ? tap_idx_t'(num_taps - 1) : idx;
    endfunction

endpackage

// File: rtl/hyperbus_delay_tap_ctrl.sv
// hyperbus_delay_tap_ctrl: sequences one-hot tap changes of the RWDS delay line while holding off the PHY.
//   clk_i        system clock
//   rst_ni       asynchronous reset, active-low
//   cfg_valid_i  new tap target valid
//   cfg_ready_o  controller can accept a target (state IDLE)
//   cfg_tap_i    target tap index, clamped to NUM_TAPS-1 at capture
//   phy_idle_i   PHY has no transaction in flight
//   phy_hold_o   PHY must not start a new transaction
//   tap_sel_o    registered one-hot select to the delay line
//   cur_tap_o    currently applied tap index
//   busy_o       update in progress
//   done_o       one-cycle pulse when an update finishes and hold is released
// Build option: HYPERBUS_DELAY_STEP_EN moves the tap one position per APPLY/SETTLE pass
// instead of jumping straight to the target.
module hyperbus_delay_tap_ctrl
    import hyperbus_delay_pkg::*;
#(
    parameter int NUM_TAPS      = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int DEFAULT_TAP   = 1,
    localparam int TAP_W        = $clog2(NUM_TAPS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [TAP_W-1:0]    cfg_tap_i,
    input  logic                phy_idle_i,
    output logic                phy_hold_o,
    output logic [NUM_TAPS-1:0] tap_sel_o,
    output logic [TAP_W-1:0]    cur_tap_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_t           state;
    logic [TAP_W-1:0] target;
    logic [TAP_W-1:0] cap_tap;
    logic [TAP_W-1:0] next_tap;
    logic [CNT_W-1:0] cnt;

    assign cfg_ready_o = state == IDLE;

    always_comb begin
        cap_tap = TAP_W'(clamp_tap(tap_idx_t'(cfg_tap_i), NUM_TAPS));
`ifdef HYPERBUS_DELAY_STEP_EN
        next_tap = target > cur_tap_o ? cur_tap_o + TAP_W'(1) : cur_tap_o - TAP_W'(1);
`else
        next_tap = target;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            target     <= TAP_W'(DEFAULT_TAP);
            cur_tap_o  <= TAP_W'(DEFAULT_TAP);
            tap_sel_o  <= NUM_TAPS'(onehot_tap(tap_idx_t'(DEFAULT_TAP)));
            cnt        <= '0;
            phy_hold_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid_i) begin
                        target <= cap_tap;
                        // Re-requesting the applied tap completes without disturbing the PHY.
                        if (cap_tap == cur_tap_o) begin
                            done_o <= 1'b1;
                        end else begin
                            state      <= WAIT_IDLE;
                            phy_hold_o <= 1'b1;
                            busy_o     <= 1'b1;
                        end
                    end
                end
                // Hold is already visible here, so an idle seen now cannot race a PHY start.
                WAIT_IDLE: if (phy_idle_i) state <= APPLY;
                APPLY: begin
                    cur_tap_o <= next_tap;
                    tap_sel_o <= NUM_TAPS'(onehot_tap(tap_idx_t'(next_tap)));
                    cnt       <= CNT_W'(SETTLE_CYCLES - 1);
                    state     <= SETTLE;
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (cur_tap_o != target) begin
                        state <= APPLY;
                    end else begin
                        state      <= IDLE;
                        phy_hold_o <= 1'b0;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_delay_tap_ctrl.sv
// tb_hyperbus_delay_tap_ctrl: directed, table-driven bench for hyperbus_delay_tap_ctrl (8-tap and 6-tap instances).
module tb_hyperbus_delay_tap_ctrl;

`ifdef HYPERBUS_DELAY_STEP_EN
    localparam bit STEP = 1'b1;
`else
    localparam bit STEP = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic [2:0] t;
        logic       rdy;
        logic       hd;
        logic       bs;
        logic       dn;
        logic [7:0] sel;
        logic [2:0] cur;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid, idle, ready, hold, busy, done;
    logic [2:0] tap, cur;
    logic [7:0] sel;
    logic       valid6, ready6, hold6, busy6, done6;
    logic [2:0] tap6, cur6;
    logic [5:0] sel6;

    int total = 0;
    int bad   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    hyperbus_delay_tap_ctrl u8 (
        .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(valid), .cfg_ready_o(ready), .cfg_tap_i(tap),
        .phy_idle_i(idle), .phy_hold_o(hold), .tap_sel_o(sel), .cur_tap_o(cur), .busy_o(busy), .done_o(done)
    );

    hyperbus_delay_tap_ctrl #(.NUM_TAPS(6)) u6 (
        .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(valid6), .cfg_ready_o(ready6), .cfg_tap_i(tap6),
        .phy_idle_i(1'b1), .phy_hold_o(hold6), .tap_sel_o(sel6), .cur_tap_o(cur6), .busy_o(busy6), .done_o(done6)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(logic v, logic [2:0] t, logic rdy, logic hd, logic bs, logic dn,
                                logic [7:0] s, logic [2:0] c);
        vec_t r;
        r.v = v; r.t = t; r.rdy = rdy; r.hd = hd; r.bs = bs; r.dn = dn; r.sel = s; r.cur = c;
        return r;
    endfunction

    function automatic int nst(int a, int b);
        return STEP ? (a > b ? a - b : b - a) : 1;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("onehot8", 32'($onehot(sel)), 32'd1);
            chk("onehot6", 32'($onehot(sel6)), 32'd1);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; valid = 1'b0; valid6 = 1'b0; idle = 1'b1; tap = '0; tap6 = '0;
        @(negedge clk);
        chk("rst sel", 32'(sel), 32'h02);
        chk("rst cur", 32'(cur), 32'd1);
        chk("rst hold", 32'(hold), 32'd0);
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst done", 32'(done), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst sel6", 32'(sel6), 32'h02);
        chk("rst cur6", 32'(cur6), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done8(input int maxc, output int n);
        n = 0;
        while (done !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done6(input int maxc, output int n);
        n = 0;
        while (done6 !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] b;
        do_reset();
        // Cycle-by-cycle expectations from the handshake cycle onward (PHY idle throughout).
        if (!STEP) begin
            tbl.push_back(mk(1, 5, 1, 0, 0, 0, 8'h02, 1));
            repeat (2) tbl.push_back(mk(0, 0, 0, 1, 1, 0, 8'h02, 1));
            repeat (4) tbl.push_back(mk(0, 0, 0, 1, 1, 0, 8'h20, 5));
            tbl.push_back(mk(0, 0, 1, 0, 0, 1, 8'h20, 5));
            tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h20, 5));
        end else begin
            tbl.push_back(mk(1, 4, 1, 0, 0, 0, 8'h02, 1));
            repeat (2) tbl.push_back(mk(0, 0, 0, 1, 1, 0, 8'h02, 1));
            b = 8'h04;
            for (int s = 0; s < 3; s++) begin
                repeat (s < 2 ? 5 : 4) tbl.push_back(mk(0, 0, 0, 1, 1, 0, b, 3'(2 + s)));
                b = b << 1;
            end
            tbl.push_back(mk(0, 0, 1, 0, 0, 1, 8'h10, 4));
            tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h10, 4));
        end
        foreach (tbl[k]) begin
            @(negedge clk);
            chk($sformatf("row%0d ready", k), 32'(ready), 32'(tbl[k].rdy));
            chk($sformatf("row%0d hold", k), 32'(hold), 32'(tbl[k].hd));
            chk($sformatf("row%0d busy", k), 32'(busy), 32'(tbl[k].bs));
            chk($sformatf("row%0d done", k), 32'(done), 32'(tbl[k].dn));
            chk($sformatf("row%0d sel", k), 32'(sel), 32'(tbl[k].sel));
            chk($sformatf("row%0d cur", k), 32'(cur), 32'(tbl[k].cur));
            valid = tbl[k].v;
            tap   = tbl[k].t;
        end

        // Busy PHY: hold stays up and the select is frozen until the PHY reports idle.
        do_reset();
        @(negedge clk);
        valid = 1'b1; tap = 3'd3; idle = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk($sformatf("busyphy%0d hold", i), 32'(hold), 32'd1);
            chk($sformatf("busyphy%0d sel", i), 32'(sel), 32'h02);
            chk($sformatf("busyphy%0d ready", i), 32'(ready), 32'd0);
            valid = i < 10;
            tap   = 3'd6;
            idle  = i == 10;
        end
        wait_done8(60, n);
        chk("busyphy latency", 32'(n), 32'(1 + 5 * nst(1, 3)));
        chk("busyphy sel", 32'(sel), 32'h08);
        chk("busyphy cur", 32'(cur), 32'd3);
        chk("busyphy hold", 32'(hold), 32'd0);

        // Same tap: immediate done, no hold.
        do_reset();
        @(negedge clk);
        chk("same hold0", 32'(hold), 32'd0);
        valid = 1'b1; tap = 3'd1;
        @(negedge clk);
        chk("same done", 32'(done), 32'd1);
        chk("same hold1", 32'(hold), 32'd0);
        chk("same busy", 32'(busy), 32'd0);
        chk("same sel", 32'(sel), 32'h02);
        chk("same ready", 32'(ready), 32'd1);
        valid = 1'b0;
        @(negedge clk);
        chk("same done off", 32'(done), 32'd0);
        chk("same hold2", 32'(hold), 32'd0);

        // Clamp on the 6-tap instance; a valid presented while busy must not be taken.
        @(negedge clk);
        valid6 = 1'b1; tap6 = 3'd7;
        @(negedge clk);
        chk("clamp ready busy", 32'(ready6), 32'd0);
        chk("clamp busy", 32'(busy6), 32'd1);
        tap6 = 3'd2;
        wait_done6(60, n);
        chk("clamp latency", 32'(n), 32'(1 + 5 * nst(1, 5)));
        chk("clamp cur", 32'(cur6), 32'd5);
        chk("clamp sel", 32'(sel6), 32'h20);
        chk("clamp ready", 32'(ready6), 32'd1);
        valid6 = 1'b0;
        @(negedge clk);
        chk("clamp idle busy", 32'(busy6), 32'd0);
        chk("clamp idle cur", 32'(cur6), 32'd5);
        chk("clamp done off", 32'(done6), 32'd0);

        // Asynchronous reset in the middle of SETTLE discards the pending target.
        do_reset();
        @(negedge clk);
        valid = 1'b1; tap = 3'd6;
        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst busy", 32'(busy), 32'd1);
        chk("midrst settle sel", 32'(sel), STEP ? 32'h04 : 32'h40);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst sel", 32'(sel), 32'h02);
        chk("midrst cur", 32'(cur), 32'd1);
        chk("midrst hold", 32'(hold), 32'd0);
        chk("midrst busy0", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d busy", i), 32'(busy), 32'd0);
            chk($sformatf("postrst%0d sel", i), 32'(sel), 32'h02);
            chk($sformatf("postrst%0d hold", i), 32'(hold), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
